chunked_add_sub: RTL and testbench
==================================

CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request a new operation; sampled only when ready=1.
REQ-006 SHALL have port sub, input, 1: mode, 0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have ports a and b, input, WIDTH each: operands; sampled with start.
REQ-008 SHALL have port ready, output, 1: high only in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, result and flags valid.
REQ-010 SHALL have port result, output, WIDTH: sum or difference.
REQ-011 SHALL have port carryOut, output, 1: carry out of MSB; for sub, 1 = no borrow.
REQ-012 SHALL have ports overflow, zero, negative, output, 1 each: signed overflow, result==0, result[WIDTH-1].

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch a, sub, and b (inverted if sub=1), set carry register to sub, clear chunk counter, and go to RUN.
REQ-015 IDLE: start=0 SHALL hold state and all outputs.
REQ-016 RUN: each cycle SHALL add chunk k of a, chunk k of b', and carry register, write CHUNK bits into result[k*CHUNK +: CHUNK], store chunk carry, increment k.
REQ-017 RUN SHALL last exactly N cycles, chunks LSB first, then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-019 Latency: start accepted at edge E SHALL give done=1 in the cycle after edge E+N; next start accepted no earlier than edge E+N+2.
REQ-020 start while ready=0 SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-021 carryOut SHALL equal the final chunk carry.
REQ-022 overflow SHALL equal (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), using latched operands.
REQ-023 zero and negative SHALL be derived from the full final result.
REQ-024 result and flags SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-025 During RUN, result MAY show partial chunks; consumers SHALL qualify result with done.
REQ-026 CHUNK == WIDTH (N=1) SHALL be legal: one RUN cycle.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; carries SHALL propagate across chunk boundaries.

Reset
REQ-028 reset_n=0 at a rising edge SHALL force IDLE, result=0, carryOut=0, overflow=0, negative=0, zero=1, done=0, ready=1, counter and carry register cleared.
REQ-029 Reset SHALL take priority over start and abort any operation in progress; no done pulse SHALL follow an aborted operation.

Verification (WIDTH=64, CHUNK=16, N=4)
REQ-030 add a=2, b=1 -> result=3, carryOut=0, zero=0; done exactly 5 cycles after start edge, one cycle wide.
REQ-031 add a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, carryOut=1, zero=1, overflow=0; checks carry ripple through all 4 chunks.
REQ-032 sub a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, carryOut=0, negative=1, overflow=0.
REQ-033 sub a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, carryOut=1.
REQ-034 start pulsed with new operands during RUN -> ignored, original result delivered; reset_n=0 in 2nd RUN cycle -> IDLE next cycle, ready=1, no done.
REQ-035 re-run REQ-030 to REQ-033 with CHUNK=64 (done 2 cycles after start edge) and CHUNK=8 (done 9 cycles after start edge) -> identical results and flags.

Source files
------------

// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock, LSB chunk first.
// Ports:
//   clk       - rising-edge clock
//   reset_n   - synchronous active-low reset
//   start     - request an operation; accepted only while ready=1
//   sub       - 0: a+b, 1: a-b (sampled with start)
//   a, b      - WIDTH-bit operands (sampled with start)
//   ready     - high while idle and able to accept start
//   done      - one-cycle pulse when result and flags are valid
//   result    - sum or difference (partial while running; qualify with done)
//   carryOut  - carry out of the MSB (for subtraction, 1 means no borrow)
//   overflow  - signed overflow
//   zero      - result is all zeros
//   negative  - result MSB
module chunked_add_sub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so N=1 still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             carry;
    logic [CW-1:0]    k;
    logic             lastChunk;
    logic [CHUNK:0]   chunkSum;

    assign lastChunk = (k == CW'(N - 1));
    // bReg already holds ~b for subtraction and carry starts at 1, giving a + ~b + 1.
    assign chunkSum  = {1'b0, aReg[k*CHUNK +: CHUNK]} + {1'b0, bReg[k*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = (state == IDLE) ? (start ? RUN : IDLE) :
                    (state == RUN)  ? (lastChunk ? DONE : RUN) : IDLE;
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aReg   <= '0;
            bReg   <= '0;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
        end else if (state == IDLE && start) begin
            aReg  <= a;
            bReg  <= sub ? ~b : b;
            carry <= sub;
            k     <= '0;
        end else if (state == RUN) begin
            result[k*CHUNK +: CHUNK] <= chunkSum[CHUNK-1:0];
            carry                    <= chunkSum[CHUNK];
            k                        <= k + 1'b1;
        end
    end

    // Flags derive from held registers, so they stay stable from done until the next accepted start.
    assign carryOut = carry;
    assign overflow = (aReg[WIDTH-1] == bReg[WIDTH-1]) && (result[WIDTH-1] != aReg[WIDTH-1]);
    assign zero     = (result == '0);
    assign negative = result[WIDTH-1];
endmodule

// File: tb/tb_chunked_add_sub.sv
// tb_chunked_add_sub: directed checks of chunked_add_sub with CHUNK=16, 64 and 8 running side by side.
module tb_chunked_add_sub;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy  [3];
    logic        dn   [3];
    logic [63:0] res  [3];
    logic        cout [3];
    logic        ovf  [3];
    logic        zr   [3];
    logic        neg  [3];
    int          checks;
    int          failures;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int CH = (g == 0) ? 16 : (g == 1) ? 64 : 8;
        chunked_add_sub #(.WIDTH(64), .CHUNK(CH)) dut (
            .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b),
            .ready(rdy[g]), .done(dn[g]), .result(res[g]), .carryOut(cout[g]),
            .overflow(ovf[g]), .zero(zr[g]), .negative(neg[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int nOf(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 8;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], dn[d], res[d], cout[d], ovf[d], zr[d], neg[d]} !== {1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset dut%0d: got rdy=%b done=%b res=%h c=%b v=%b z=%b n=%b, want rdy=1 done=0 res=0 c=0 v=0 z=1 n=0",
                         d, rdy[d], dn[d], res[d], cout[d], ovf[d], zr[d], neg[d]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_op(input string name, input logic s, input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] er, input logic ec, input logic ez, input logic en, input logic ev);
        int first[3];
        int cnt[3];
        @(negedge clk);
        sub   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = '{-1, -1, -1};
        cnt   = '{0, 0, 0};
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (dn[d]) begin
                    cnt[d]++;
                    if (first[d] < 0) begin
                        first[d] = i;
                        checks++;
                        if ({res[d], cout[d], zr[d], neg[d], ovf[d]} !== {er, ec, ez, en, ev}) begin
                            failures++;
                            $display("FAIL %s dut%0d: got res=%h c=%b z=%b n=%b v=%b, want res=%h c=%b z=%b n=%b v=%b",
                                     name, d, res[d], cout[d], zr[d], neg[d], ovf[d], er, ec, ez, en, ev);
                        end
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (first[d] !== nOf(d) || cnt[d] !== 1) begin
                failures++;
                $display("FAIL %s_latency dut%0d: got done first at +%0d width %0d, want +%0d width 1",
                         name, d, first[d], cnt[d], nOf(d));
            end
            checks++;
            if ({rdy[d], res[d], cout[d], ovf[d]} !== {1'b1, er, ec, ev}) begin
                failures++;
                $display("FAIL %s_hold dut%0d: got rdy=%b res=%h c=%b v=%b, want rdy=1 res=%h c=%b v=%b",
                         name, d, rdy[d], res[d], cout[d], ovf[d], er, ec, ev);
            end
        end
    endtask

    task automatic test_ignore_start;
        int cnt[3];
        logic [63:0] got[3];
        @(negedge clk);
        sub   = 1'b0;
        a     = 64'd2;
        b     = 64'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt   = '{0, 0, 0};
        got   = '{64'hx, 64'hx, 64'hx};
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (dn[d]) begin
                    cnt[d]++;
                    got[d] = res[d];
                end
            end
            if (i == 1) begin
                @(negedge clk);
                sub   = 1'b1;
                a     = 64'h1234;
                b     = 64'h1111;
                start = 1'b1;
            end
            if (i == 2) start = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (cnt[d] !== 1 || got[d] !== 64'd3) begin
                failures++;
                $display("FAIL ignore_start dut%0d: got %0d done pulses res=%h, want 1 pulse res=3", d, cnt[d], got[d]);
            end
        end
    endtask

    task automatic test_abort;
        int cnt[3];
        @(negedge clk);
        sub   = 1'b0;
        a     = 64'd2;
        b     = 64'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], dn[d], res[d]} !== {1'b1, 1'b0, 64'h0}) begin
                failures++;
                $display("FAIL abort dut%0d: got rdy=%b done=%b res=%h, want rdy=1 done=0 res=0", d, rdy[d], dn[d], res[d]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        cnt     = '{0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) if (dn[d]) cnt[d]++;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (cnt[d] !== 0 || rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL abort_no_done dut%0d: got %0d done pulses rdy=%b, want 0 pulses rdy=1", d, cnt[d], rdy[d]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_op("add_small", 1'b0, 64'd2, 64'd1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        test_op("add_ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        test_op("sub_neg", 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        test_op("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        test_op("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        test_ignore_start();
        test_abort();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
